// File: rtl/blackjack_pkg.sv
// Shared deck constants, card record and dealer state encoding for the blackjack datapath.
package blackjack_pkg;

  localparam int DECK_SIZE  = 52;
  localparam int CARD_IDX_W = 6;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [4:0] points;
  } card_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DEAL  = 2'd2
  } dealer_state_t;

  // Linear probe step through the deck: 51 wraps back to 0.
  function automatic logic [CARD_IDX_W-1:0] next_card_idx(input logic [CARD_IDX_W-1:0] idx);
    return (idx == CARD_IDX_W'(DECK_SIZE - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card index -> rank/suit/points decode, shared with the hand scoring logic.
module card_decode
  import blackjack_pkg::*;
#(
  parameter int ACE_POINTS = 11
) (
  input  logic [CARD_IDX_W-1:0] index,
  output card_t                 card
);

  always_comb begin
    card.rank = index[5:2] + 4'd1;
    card.suit = index[1:0];
    if (card.rank == 4'd1) begin
      card.points = 5'(ACE_POINTS);
    end else if (card.rank > 4'd10) begin
      card.points = 5'd10;
    end else begin
      card.points = {1'b0, card.rank};
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from one 52-card deck by linear probing from a random start index.
// Build option CARD_DEALER_PROBE_CNT_EN adds o_probe_count (probes skipped on the last deal).
//
// state | meaning
// IDLE  | waiting for a draw request
// PROBE | testing candidate index against the dealt bitmap, one per cycle
// DEAL  | o_card_valid strobe, new card on o_card_*
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int RAND_WIDTH = 16,
  parameter int ACE_POINTS = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [RAND_WIDTH-1:0] i_rand_value,
  input  logic                  i_draw_req,
  input  logic                  i_shuffle,
  output logic                  o_busy,
  output logic                  o_card_valid,
  output logic [CARD_IDX_W-1:0] o_card_index,
  output logic [3:0]            o_card_rank,
  output logic [1:0]            o_card_suit,
  output logic [4:0]            o_card_points,
  output logic [CARD_IDX_W-1:0] o_cards_left,
  output logic                  o_deck_empty
`ifdef CARD_DEALER_PROBE_CNT_EN
  ,
  output logic [CARD_IDX_W-1:0] o_probe_count
`endif
);

  dealer_state_t         state_q, state_d;
  logic [DECK_SIZE-1:0]  dealt_q;
  logic [CARD_IDX_W-1:0] cand_q;
  logic [CARD_IDX_W-1:0] cards_left_q;
  logic [CARD_IDX_W-1:0] card_index_q;
  card_t                 card_q;
  card_t                 cand_card;
  logic [CARD_IDX_W-1:0] rand_idx;
  logic [CARD_IDX_W-1:0] start_idx;
  logic                  deck_empty;
  logic                  draw_start;
  logic                  cand_free;
  logic                  unused_rand_hi;

  assign unused_rand_hi = ^i_rand_value[RAND_WIDTH-1:CARD_IDX_W];

  // Values 52..63 fold onto 0..11 so every raw sample maps into the deck.
  assign rand_idx   = i_rand_value[CARD_IDX_W-1:0];
  assign start_idx  = (rand_idx >= CARD_IDX_W'(DECK_SIZE)) ? rand_idx - CARD_IDX_W'(DECK_SIZE)
                                                           : rand_idx;
  assign deck_empty = (cards_left_q == '0);
  assign draw_start = (state_q == IDLE) && i_draw_req && !deck_empty && !i_shuffle;
  assign cand_free  = !dealt_q[cand_q];

  card_decode #(
    .ACE_POINTS(ACE_POINTS)
  ) u_card_decode (
    .index(cand_q),
    .card (cand_card)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_shuffle) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (draw_start) state_d = PROBE;
        PROBE:   if (cand_free)  state_d = DEAL;
        DEAL:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dealt_q      <= '0;
      cand_q       <= '0;
      cards_left_q <= CARD_IDX_W'(DECK_SIZE);
      card_index_q <= '0;
      card_q       <= '0;
    end else if (i_shuffle) begin
      dealt_q      <= '0;
      cards_left_q <= CARD_IDX_W'(DECK_SIZE);
    end else if (draw_start) begin
      cand_q <= start_idx;
    end else if (state_q == PROBE) begin
      if (cand_free) begin
        dealt_q[cand_q] <= 1'b1;
        cards_left_q    <= cards_left_q - 1'b1;
        card_index_q    <= cand_q;
        card_q          <= cand_card;
      end else begin
        cand_q <= next_card_idx(cand_q);
      end
    end
  end

`ifdef CARD_DEALER_PROBE_CNT_EN
  logic [CARD_IDX_W-1:0] skip_q;
  logic [CARD_IDX_W-1:0] probe_count_q;

  // Skips accumulate during the search and are published together with the strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skip_q        <= '0;
      probe_count_q <= '0;
    end else if (!i_shuffle) begin
      if (draw_start) begin
        skip_q <= '0;
      end else if (state_q == PROBE) begin
        if (cand_free) begin
          probe_count_q <= skip_q;
        end else begin
          skip_q <= skip_q + 1'b1;
        end
      end
    end
  end

  assign o_probe_count = probe_count_q;
`endif

  assign o_busy        = (state_q != IDLE);
  assign o_card_valid  = (state_q == DEAL);
  assign o_card_index  = card_index_q;
  assign o_card_rank   = card_q.rank;
  assign o_card_suit   = card_q.suit;
  assign o_card_points = card_q.points;
  assign o_cards_left  = cards_left_q;
  assign o_deck_empty  = deck_empty;

endmodule
